// File: rtl/spi_slave_ctrl_if.sv
// SPI slave bus bundle: serial pins plus the RAM-facing word/byte handshake.
// The master side is the host/RAM environment; the slave side is spi_slave_ctrl.
interface spi_slave_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              SS_n;
  logic              MOSI;
  logic              MISO;
  logic [DATA_W+1:0] rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid
  );

  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid
  );
endinterface

// File: rtl/spi_slave_ctrl.sv
// SPI slave front-end: deserialises {cmd,data} words from MOSI and
// serialises the RAM read byte on MISO, everything on posedge of the SPI clock.
module spi_slave_ctrl #(
  parameter int DATA_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_slave_ctrl_if.slave bus
);

  localparam int WORD_W = DATA_W + 2;
  localparam int CNT_W  = $clog2(WORD_W + 1);
  localparam int TXC_W  = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]  cnt_q;
  logic [WORD_W-2:0] sr_q;
  logic              rd_addr_seen_q;
  logic [DATA_W-1:0] tx_sr_q;
  logic [TXC_W-1:0]  tx_cnt_q;
  logic              tx_busy_q;
  logic              tx_done_q;
  logic              miso_q;
  logic [WORD_W-1:0] rx_data_q;
  logic              rx_valid_q;

  logic in_frame;
  logic word_last;
  logic word_full;

  assign in_frame  = (state_q != IDLE) && !bus.SS_n;
  assign word_last = (cnt_q == CNT_W'(WORD_W - 1));
  assign word_full = (cnt_q == CNT_W'(WORD_W));

  assign bus.MISO     = miso_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (!bus.SS_n) state_d = CHK_CMD;
      end
      CHK_CMD: begin
        if (bus.SS_n)          state_d = IDLE;
        else if (!bus.MOSI)    state_d = WRITE;
        else if (rd_addr_seen_q) state_d = READ_DATA;
        else                   state_d = READ_ADD;
      end
      default: begin
        if (bus.SS_n) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      sr_q           <= '0;
      rd_addr_seen_q <= 1'b0;
      tx_sr_q        <= '0;
      tx_cnt_q       <= '0;
      tx_busy_q      <= 1'b0;
      tx_done_q      <= 1'b0;
      miso_q         <= 1'b0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (!in_frame) begin
        cnt_q     <= '0;
        tx_busy_q <= 1'b0;
        tx_done_q <= 1'b0;
        miso_q    <= 1'b0;
      end else if (!word_full) begin
        sr_q  <= {sr_q[WORD_W-3:0], bus.MOSI};
        cnt_q <= cnt_q + CNT_W'(1);
        if (word_last) begin
          rx_data_q  <= {sr_q, bus.MOSI};
          rx_valid_q <= 1'b1;
          if (state_q == READ_ADD)  rd_addr_seen_q <= 1'b1;
          if (state_q == READ_DATA) rd_addr_seen_q <= 1'b0;
        end
      end else if (state_q == READ_DATA) begin
        // one byte per frame: tx_done blocks any later tx_valid
        if (tx_busy_q) begin
          if (tx_cnt_q != '0) begin
            miso_q   <= tx_sr_q[DATA_W-1];
            tx_sr_q  <= tx_sr_q << 1;
            tx_cnt_q <= tx_cnt_q - TXC_W'(1);
          end else begin
            miso_q    <= 1'b0;
            tx_busy_q <= 1'b0;
            tx_done_q <= 1'b1;
          end
        end else if (!tx_done_q && bus.tx_valid) begin
          miso_q    <= bus.tx_data[DATA_W-1];
          tx_sr_q   <= bus.tx_data << 1;
          tx_cnt_q  <= TXC_W'(DATA_W - 1);
          tx_busy_q <= 1'b1;
        end
      end
    end
  end

endmodule
